// File: rtl/button_event_pkg.sv
// Shared types for the button event arbiter:
// event kinds reported to the consumer and per-button tracker states.
package button_event_pkg;

  typedef enum logic [1:0] {
    EV_PRESS   = 2'd0,
    EV_RELEASE = 2'd1,
    EV_LONG    = 2'd2,
    EV_REPEAT  = 2'd3
  } event_kind_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HELD = 2'd1,
    S_LONG = 2'd2
  } button_state_t;

endpackage

// File: rtl/button_tracker.sv
// One button: edge detect, press/long/repeat timing and a single
// pending event slot that is overwritten (with a drop pulse) if not granted.
module button_tracker
  import button_event_pkg::*;
#(
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_level,
  input  logic       i_grant,
  output logic       o_pending,
  output logic [1:0] o_kind,
  output logic       o_dropped
);

  localparam int MAXT = (LONG_TICKS > REPEAT_TICKS) ?
                        LONG_TICKS : REPEAT_TICKS;
  localparam int CW = $clog2(MAXT + 1);
  localparam logic [CW-1:0] LONG_END = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] REP_END  = CW'(REPEAT_TICKS - 1);

  button_state_t r_state;
  button_state_t w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_prev;
  logic          r_pend;
  event_kind_t   r_kind;
  logic          r_drop;
  logic          w_rise;
  logic          w_fall;
  logic          w_raise;
  event_kind_t   w_raise_kind;

  assign w_rise = i_level & ~r_prev;
  assign w_fall = ~i_level & r_prev;

  // Release wins over a counter terminal in the same cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_raise      = 1'b0;
    w_raise_kind = EV_PRESS;
    unique case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_state_nxt  = S_HELD;
          w_cnt_nxt    = '0;
          w_raise      = 1'b1;
          w_raise_kind = EV_PRESS;
        end
      end
      S_HELD: begin
        if (w_fall) begin
          w_state_nxt  = S_IDLE;
          w_cnt_nxt    = '0;
          w_raise      = 1'b1;
          w_raise_kind = EV_RELEASE;
        end else if (r_cnt == LONG_END) begin
          w_state_nxt  = S_LONG;
          w_cnt_nxt    = '0;
          w_raise      = 1'b1;
          w_raise_kind = EV_LONG;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_LONG: begin
        if (w_fall) begin
          w_state_nxt  = S_IDLE;
          w_cnt_nxt    = '0;
          w_raise      = 1'b1;
          w_raise_kind = EV_RELEASE;
        end else if (r_cnt == REP_END) begin
          w_cnt_nxt    = '0;
          w_raise      = 1'b1;
          w_raise_kind = EV_REPEAT;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_prev  <= 1'b0;
      r_pend  <= 1'b0;
      r_kind  <= EV_PRESS;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_prev  <= i_level;
      r_drop  <= w_raise & r_pend & ~i_grant;
      if (w_raise) begin
        r_pend <= 1'b1;
        r_kind <= w_raise_kind;
      end else if (i_grant) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign o_pending = r_pend;
  assign o_kind    = r_kind;
  assign o_dropped = r_drop;

endmodule

// File: rtl/button_event_arbiter.sv
// Per-button event trackers feeding a round-robin arbiter
// and a single registered valid/ready event port.
module button_event_arbiter
  import button_event_pkg::*;
#(
  parameter int N_BUTTONS    = 3,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 250
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_BUTTONS-1:0]         buttons,
  output logic                         event_valid,
  input  logic                         event_ready,
  output logic [$clog2(N_BUTTONS)-1:0] event_id,
  output logic [1:0]                   event_kind,
  output logic [N_BUTTONS-1:0]         dropped
);

  localparam int IDW = $clog2(N_BUTTONS);

  logic [N_BUTTONS-1:0] w_pend;
  logic [N_BUTTONS-1:0] w_grant;
  logic [N_BUTTONS-1:0] w_drop;
  logic [1:0]           w_kind [N_BUTTONS];
  logic [IDW-1:0]       r_ptr;
  logic                 r_valid;
  logic [IDW-1:0]       r_id;
  logic [1:0]           r_kind;
  logic                 w_free;
  logic                 w_found;
  logic                 w_load;
  logic [IDW-1:0]       w_win;
  logic [IDW-1:0]       w_ptr_nxt;
  int                   w_idx;

  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_btn
    button_tracker #(
      .LONG_TICKS   (LONG_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
    ) u_trk (
      .clk       (clk),
      .rst       (rst),
      .i_level   (buttons[g]),
      .i_grant   (w_grant[g]),
      .o_pending (w_pend[g]),
      .o_kind    (w_kind[g]),
      .o_dropped (w_drop[g])
    );
  end

  // First pending slot at or after the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int off = 0; off < N_BUTTONS; off++) begin
      w_idx = (int'(r_ptr) + off) % N_BUTTONS;
      if (!w_found && w_pend[w_idx]) begin
        w_found = 1'b1;
        w_win   = IDW'(w_idx);
      end
    end
  end

  assign w_free    = ~r_valid | event_ready;
  assign w_load    = w_free & w_found;
  assign w_grant   = w_load ? (N_BUTTONS'(1) << w_win) : '0;
  assign w_ptr_nxt = (w_win == IDW'(N_BUTTONS - 1)) ?
                     '0 : w_win + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_id    <= '0;
      r_kind  <= '0;
      r_ptr   <= '0;
    end else if (w_free) begin
      r_valid <= w_found;
      if (w_found) begin
        r_id   <= w_win;
        r_kind <= w_kind[w_win];
        r_ptr  <= w_ptr_nxt;
      end
    end
  end

  assign event_valid = r_valid;
  assign event_id    = r_id;
  assign event_kind  = r_kind;
  assign dropped     = w_drop;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed vector bench for button_event_arbiter
// (N=3, LONG_TICKS=10, REPEAT_TICKS=8).
module tb_button_event_arbiter;

  localparam int N  = 3;
  localparam int KP = 0;
  localparam int KR = 1;
  localparam int KL = 2;
  localparam int KT = 3;

  typedef struct {
    logic [2:0] b;
    logic       r;
    logic       v;
    logic [1:0] id;
    logic [1:0] k;
    logic [2:0] d;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] buttons;
  logic       event_valid;
  logic       event_ready;
  logic [1:0] event_id;
  logic [1:0] event_kind;
  logic [2:0] dropped;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  button_event_arbiter #(
    .N_BUTTONS    (N),
    .LONG_TICKS   (10),
    .REPEAT_TICKS (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .buttons     (buttons),
    .event_valid (event_valid),
    .event_ready (event_ready),
    .event_id    (event_id),
    .event_kind  (event_kind),
    .dropped     (dropped)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int b, input int r, input int v,
                     input int id, input int k, input int d);
    vec_t t;
    t.b  = 3'(b);
    t.r  = 1'(r);
    t.v  = 1'(v);
    t.id = 2'(id);
    t.k  = 2'(k);
    t.d  = 3'(d);
    vecs.push_back(t);
  endtask

  task automatic chk_out(input string tag, input int v, input int id,
                         input int k, input int d);
    chk({tag, " valid"}, int'(event_valid), v);
    chk({tag, " dropped"}, int'(dropped), d);
    if (v != 0) begin
      chk({tag, " id"}, int'(event_id), id);
      chk({tag, " kind"}, int'(event_kind), k);
    end
  endtask

  initial begin
    // idle after reset
    for (int i = 0; i < 20; i++) add(0, 1, 0, 0, 0, 0);
    // simultaneous burst from pointer 0, then release
    add(7, 1, 0, 0, 0, 0);
    add(7, 1, 1, 0, KP, 0);
    add(7, 1, 1, 1, KP, 0);
    add(7, 1, 1, 2, KP, 0);
    add(7, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, KR, 0);
    add(0, 1, 1, 1, KR, 0);
    add(0, 1, 1, 2, KR, 0);
    add(0, 1, 0, 0, 0, 0);
    // short press of button 1
    add(2, 1, 0, 0, 0, 0);
    add(2, 1, 1, 1, KP, 0);
    add(2, 1, 0, 0, 0, 0);
    add(2, 1, 0, 0, 0, 0);
    add(2, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0);
    add(0, 1, 1, 1, KR, 0);
    add(0, 1, 0, 0, 0, 0);
    // burst resumes at pointer 2
    add(7, 1, 0, 0, 0, 0);
    add(7, 1, 1, 2, KP, 0);
    add(7, 1, 1, 0, KP, 0);
    add(7, 1, 1, 1, KP, 0);
    add(7, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0);
    add(0, 1, 1, 2, KR, 0);
    add(0, 1, 1, 0, KR, 0);
    add(0, 1, 1, 1, KR, 0);
    add(0, 1, 0, 0, 0, 0);
    // backpressure on button 2 with overwrites
    add(4, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) add(4, 0, 1, 2, KP, 0);
    add(0, 0, 1, 2, KP, 0);
    add(0, 0, 1, 2, KP, 0);
    add(4, 0, 1, 2, KP, 4);
    add(4, 0, 1, 2, KP, 0);
    add(0, 0, 1, 2, KP, 4);
    for (int i = 10; i < 30; i++) add(0, 0, 1, 2, KP, 0);
    add(0, 1, 1, 2, KR, 0);
    add(0, 1, 0, 0, 0, 0);

    rst = 1'b1;
    buttons = '0;
    event_ready = 1'b1;
    step();
    step();
    chk_out("reset", 0, 0, 0, 0);
    chk("reset id", int'(event_id), 0);
    chk("reset kind", int'(event_kind), 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      buttons = vecs[i].b;
      event_ready = vecs[i].r;
      step();
      chk_out($sformatf("vec%0d", i), int'(vecs[i].v),
              int'(vecs[i].id), int'(vecs[i].k), int'(vecs[i].d));
    end

    // long hold of button 0: PRESS, LONG +10, REPEAT +18/+26/+34, RELEASE
    event_ready = 1'b1;
    for (int j = 0; j < 43; j++) begin
      int e;
      int v;
      int k;
      buttons = (j < 40) ? 3'b001 : 3'b000;
      step();
      e = j - 1;
      v = (e == 0 || e == 10 || e == 18 || e == 26 ||
           e == 34 || e == 40) ? 1 : 0;
      k = (e == 0) ? KP : (e == 10) ? KL : (e == 40) ? KR : KT;
      chk_out($sformatf("hold%0d", j), v, 0, k, 0);
    end

    // reset while an event is held and button 0 is in S_LONG
    event_ready = 1'b0;
    buttons = 3'b001;
    for (int j = 0; j < 13; j++) step();
    chk_out("pre-rst", 1, 0, KP, 0);
    rst = 1'b1;
    buttons = 3'b000;
    #1;
    chk_out("async rst", 0, 0, 0, 0);
    chk("async rst id", int'(event_id), 0);
    chk("async rst kind", int'(event_kind), 0);
    step();
    step();
    rst = 1'b0;
    event_ready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      step();
      chk_out($sformatf("post-rst%0d", j), 0, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
